// File: rtl/txll_arb.sv
// rtl/txll_arb.sv - frame-atomic round-robin arbiter for the SATA link-layer transmit port
// Optional stalled-frame watchdog enabled by defining SATA_TXARB_WDT_EN.
module txll_arb #(
  parameter int unsigned C_TIMEOUT = 1023
) (
  input  logic        phyclk,
  input  logic        phyreset_n,
  input  logic [31:0] req0_td,
  input  logic        req0_tsof_n,
  input  logic        req0_teof_n,
  input  logic        req0_tsrc_rdy_n,
  output logic        req0_tdst_rdy_n,
  output logic        req0_tdst_dsc_n,
  input  logic [31:0] req1_td,
  input  logic        req1_tsof_n,
  input  logic        req1_teof_n,
  input  logic        req1_tsrc_rdy_n,
  output logic        req1_tdst_rdy_n,
  output logic        req1_tdst_dsc_n,
  output logic [31:0] trn_td,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tdst_dsc_n,
  output logic [1:0]  grant,
  output logic        err_nosof,
  output logic        wdt_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;

  logic        busy;
  logic        sel;
  logic [31:0] g_td;
  logic        g_sof_n, g_eof_n, g_vld_n;
  logic        beat_acc;
  logic        wdt_fire;
  logic        elig0, elig1;

  if ((C_TIMEOUT < 2) || (C_TIMEOUT > 65535)) begin : g_bad_timeout
    $error("txll_arb: C_TIMEOUT out of range");
  end

  assign busy     = (state_q == S_GNT0) || (state_q == S_GNT1);
  assign sel      = (state_q == S_GNT1);
  assign g_td     = sel ? req1_td         : req0_td;
  assign g_sof_n  = sel ? req1_tsof_n     : req0_tsof_n;
  assign g_eof_n  = sel ? req1_teof_n     : req0_teof_n;
  assign g_vld_n  = sel ? req1_tsrc_rdy_n : req0_tsrc_rdy_n;
  assign beat_acc = busy && !g_vld_n && !trn_tdst_rdy_n;
  assign elig0    = !req0_tsrc_rdy_n && !req0_tsof_n;
  assign elig1    = !req1_tsrc_rdy_n && !req1_tsof_n;

`ifdef SATA_TXARB_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(C_TIMEOUT - 1);

  logic [15:0] wdt_cnt_q, wdt_cnt_d;

  // Held at zero while idle, so every grant starts counting from zero.
  always_comb begin
    wdt_cnt_d = '0;
    if (busy && !beat_acc) begin
      wdt_cnt_d = wdt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge phyclk) begin
    if (!phyreset_n) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end

  assign wdt_fire = busy && (wdt_cnt_q == WDT_LAST);
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge phyclk) begin
    if (!phyreset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    trn_td          = '0;
    trn_tsof_n      = 1'b1;
    trn_teof_n      = 1'b1;
    trn_tsrc_rdy_n  = 1'b1;
    trn_tsrc_dsc_n  = 1'b1;
    req0_tdst_rdy_n = 1'b1;
    req1_tdst_rdy_n = 1'b1;
    req0_tdst_dsc_n = 1'b1;
    req1_tdst_dsc_n = 1'b1;
    grant           = 2'b00;
    err_nosof       = 1'b0;
    wdt_abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (phyreset_n) begin
          // Head beats without SOF are swallowed so a requester can never wedge the port.
          if (!req0_tsrc_rdy_n && req0_tsof_n) begin
            req0_tdst_rdy_n = 1'b0;
            err_nosof       = 1'b1;
          end
          if (!req1_tsrc_rdy_n && req1_tsof_n) begin
            req1_tdst_rdy_n = 1'b0;
            err_nosof       = 1'b1;
          end
          if (elig0 && elig1) begin
            state_d = last_grant_q ? S_GNT0 : S_GNT1;
          end else if (elig0) begin
            state_d = S_GNT0;
          end else if (elig1) begin
            state_d = S_GNT1;
          end
        end
      end

      S_GNT0, S_GNT1: begin
        trn_td         = g_td;
        trn_tsof_n     = g_sof_n;
        trn_teof_n     = g_eof_n;
        trn_tsrc_rdy_n = g_vld_n;
        grant          = sel ? 2'b10 : 2'b01;
        if (sel) begin
          req1_tdst_rdy_n = trn_tdst_rdy_n;
        end else begin
          req0_tdst_rdy_n = trn_tdst_rdy_n;
        end

        // Link discontinue and watchdog abort both outrank a same-cycle EOF.
        if (!trn_tdst_dsc_n || wdt_fire) begin
          if (sel) begin
            req1_tdst_dsc_n = 1'b0;
          end else begin
            req0_tdst_dsc_n = 1'b0;
          end
          trn_tsrc_dsc_n = !wdt_fire;
          wdt_abort      = wdt_fire;
          state_d        = S_IDLE;
          last_grant_d   = sel;
        end else if (beat_acc && !g_eof_n) begin
          state_d      = S_IDLE;
          last_grant_d = sel;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_txll_arb.sv
// tb/tb_txll_arb.sv - directed self-checking bench for txll_arb
// Watchdog scenario selected when SATA_TXARB_WDT_EN is defined.
module tb_txll_arb;

  logic        phyclk = 1'b0;
  logic        phyreset_n;
  logic [31:0] r0_td, r1_td;
  logic        r0_sof_n, r0_eof_n, r0_vld_n;
  logic        r1_sof_n, r1_eof_n, r1_vld_n;
  logic        req0_tdst_rdy_n, req0_tdst_dsc_n, req1_tdst_rdy_n, req1_tdst_dsc_n;
  logic [31:0] trn_td;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        t_rdy_n, t_dsc_n;
  logic [1:0]  grant;
  logic        err_nosof, wdt_abort;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 phyclk = ~phyclk;

  txll_arb #(.C_TIMEOUT(8)) dut (
    .phyclk          (phyclk),
    .phyreset_n      (phyreset_n),
    .req0_td         (r0_td),
    .req0_tsof_n     (r0_sof_n),
    .req0_teof_n     (r0_eof_n),
    .req0_tsrc_rdy_n (r0_vld_n),
    .req0_tdst_rdy_n (req0_tdst_rdy_n),
    .req0_tdst_dsc_n (req0_tdst_dsc_n),
    .req1_td         (r1_td),
    .req1_tsof_n     (r1_sof_n),
    .req1_teof_n     (r1_eof_n),
    .req1_tsrc_rdy_n (r1_vld_n),
    .req1_tdst_rdy_n (req1_tdst_rdy_n),
    .req1_tdst_dsc_n (req1_tdst_dsc_n),
    .trn_td          (trn_td),
    .trn_tsof_n      (trn_tsof_n),
    .trn_teof_n      (trn_teof_n),
    .trn_tsrc_rdy_n  (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n  (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n  (t_rdy_n),
    .trn_tdst_dsc_n  (t_dsc_n),
    .grant           (grant),
    .err_nosof       (err_nosof),
    .wdt_abort       (wdt_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge phyclk);
    #1;
  endtask

  task automatic drv0(input logic vld_n, input logic sof_n, input logic eof_n, input logic [31:0] td);
    r0_vld_n = vld_n; r0_sof_n = sof_n; r0_eof_n = eof_n; r0_td = td;
  endtask

  task automatic drv1(input logic vld_n, input logic sof_n, input logic eof_n, input logic [31:0] td);
    r1_vld_n = vld_n; r1_sof_n = sof_n; r1_eof_n = eof_n; r1_td = td;
  endtask

  task automatic idle_inputs();
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    drv1(1'b1, 1'b1, 1'b1, 32'h0);
    t_rdy_n = 1'b0;
    t_dsc_n = 1'b1;
  endtask

  task automatic do_reset();
    phyreset_n = 1'b0;
    next_cycle();
    phyreset_n = 1'b1;
  endtask

  logic [31:0] got_q[$];
  logic [31:0] exp_td;
  logic [1:0]  exp_g;
  int          b;

  initial begin
    idle_inputs();
    phyreset_n = 1'b0;
    next_cycle();
    next_cycle();

    // Reset state, sampled while reset is still held.
    @(negedge phyclk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_trn_n", {28'h0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 32'hF);
    check("rst_req_n", {28'h0, req0_tdst_rdy_n, req0_tdst_dsc_n, req1_tdst_rdy_n, req1_tdst_dsc_n}, 32'hF);
    check("rst_td", trn_td, 32'h0);
    check("rst_pulses", {30'h0, err_nosof, wdt_abort}, 32'h0);
    next_cycle();
    phyreset_n = 1'b1;

    // req0 four-beat frame 0xA0..0xA3.
    drv0(1'b0, 1'b0, 1'b1, 32'hA0);
    @(negedge phyclk);
    check("f4_c0_grant", 32'(grant), 32'h0);
    check("f4_c0_hold", 32'(req0_tdst_rdy_n), 32'h1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drv0(1'b0, i != 0, i != 3, 32'hA0 + 32'(i));
      @(negedge phyclk);
      check($sformatf("f4_grant%0d", i), 32'(grant), 32'h1);
      check($sformatf("f4_td%0d", i), trn_td, 32'hA0 + 32'(i));
      check($sformatf("f4_fr%0d", i), {30'h0, trn_tsof_n, trn_teof_n}, {30'h0, i != 0, i != 3});
      check($sformatf("f4_nosof%0d", i), 32'(err_nosof), 32'h0);
      next_cycle();
    end
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge phyclk);
    check("f4_idle_grant", 32'(grant), 32'h0);
    check("f4_idle_nosof", 32'(err_nosof), 32'h0);
    next_cycle();

    // Tie round-robin with single-beat frames: 0,1,0,1 and one idle bubble between.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k <= 5) drv0(1'b0, 1'b0, 1'b0, (k <= 1) ? 32'hB0 : 32'hB1);
      else        drv0(1'b1, 1'b1, 1'b1, 32'h0);
      if (k <= 7) drv1(1'b0, 1'b0, 1'b0, (k <= 3) ? 32'hC0 : 32'hC1);
      else        drv1(1'b1, 1'b1, 1'b1, 32'h0);
      case (k)
        1: begin exp_g = 2'b01; exp_td = 32'hB0; end
        3: begin exp_g = 2'b10; exp_td = 32'hC0; end
        5: begin exp_g = 2'b01; exp_td = 32'hB1; end
        7: begin exp_g = 2'b10; exp_td = 32'hC1; end
        default: begin exp_g = 2'b00; exp_td = 32'h0; end
      endcase
      @(negedge phyclk);
      check($sformatf("rr_grant%0d", k), 32'(grant), 32'(exp_g));
      check($sformatf("rr_td%0d", k), trn_td, exp_td);
      next_cycle();
    end

    // req1 three-beat frame with link ready toggling.
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      b = (k == 0) ? 0 : (k - 1) / 2;
      if (k < 7) drv1(1'b0, b != 0, b != 2, 32'hD0 + 32'(b));
      else       drv1(1'b1, 1'b1, 1'b1, 32'h0);
      t_rdy_n = (k % 2 == 1);
      @(negedge phyclk);
      check($sformatf("tg_r0rdy%0d", k), 32'(req0_tdst_rdy_n), 32'h1);
      if (k >= 1 && k <= 6) begin
        check($sformatf("tg_td%0d", k), trn_td, 32'hD0 + 32'(b));
        check($sformatf("tg_r1rdy%0d", k), 32'(req1_tdst_rdy_n), 32'(t_rdy_n));
      end else begin
        check($sformatf("tg_grant%0d", k), 32'(grant), 32'h0);
      end
      if (!trn_tsrc_rdy_n && !t_rdy_n) got_q.push_back(trn_td);
      next_cycle();
    end
    t_rdy_n = 1'b0;
    check("tg_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      check($sformatf("tg_beat%0d", i), got_q[i], 32'hD0 + 32'(i));
    end

    // Link discontinue on the second req0 beat, req1 SOF pending.
    drv0(1'b0, 1'b0, 1'b1, 32'hE0);
    drv1(1'b0, 1'b0, 1'b0, 32'hF0);
    @(negedge phyclk);
    check("dsc_c0_grant", 32'(grant), 32'h0);
    next_cycle();
    @(negedge phyclk);
    check("dsc_c1_grant", 32'(grant), 32'h1);
    next_cycle();
    drv0(1'b0, 1'b1, 1'b1, 32'hE1);
    t_dsc_n = 1'b0;
    @(negedge phyclk);
    check("dsc_r0_pulse", 32'(req0_tdst_dsc_n), 32'h0);
    check("dsc_r1_quiet", 32'(req1_tdst_dsc_n), 32'h1);
    check("dsc_tsrc_dsc", 32'(trn_tsrc_dsc_n), 32'h1);
    next_cycle();
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    t_dsc_n = 1'b1;
    @(negedge phyclk);
    check("dsc_idle_grant", 32'(grant), 32'h0);
    check("dsc_idle_pulse", 32'(req0_tdst_dsc_n), 32'h1);
    next_cycle();
    @(negedge phyclk);
    check("dsc_r1_grant", 32'(grant), 32'h2);
    check("dsc_r1_td", trn_td, 32'hF0);
    check("dsc_r1_sof", 32'(trn_tsof_n), 32'h0);
    next_cycle();
    drv1(1'b1, 1'b1, 1'b1, 32'h0);

    // Non-SOF head beat in IDLE is discarded.
    drv1(1'b0, 1'b1, 1'b1, 32'hDEAD);
    @(negedge phyclk);
    check("ns_grant", 32'(grant), 32'h0);
    check("ns_r1rdy", 32'(req1_tdst_rdy_n), 32'h0);
    check("ns_r0rdy", 32'(req0_tdst_rdy_n), 32'h1);
    check("ns_err", 32'(err_nosof), 32'h1);
    check("ns_trn_vld", 32'(trn_tsrc_rdy_n), 32'h1);
    next_cycle();
    drv1(1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge phyclk);
    check("ns_err_once", 32'(err_nosof), 32'h0);
    check("ns_grant_after", 32'(grant), 32'h0);
    next_cycle();

    // Stalled req0 grant: watchdog abort, or indefinite hold without it.
    drv0(1'b0, 1'b0, 1'b0, 32'h77);
    t_rdy_n = 1'b1;
    next_cycle();
`ifdef SATA_TXARB_WDT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge phyclk);
      check($sformatf("wdt_grant%0d", k), 32'(grant), 32'h1);
      check($sformatf("wdt_abort%0d", k), 32'(wdt_abort), 32'(k == 8));
      check($sformatf("wdt_tdsc%0d", k), 32'(trn_tsrc_dsc_n), 32'(k != 8));
      check($sformatf("wdt_r0dsc%0d", k), 32'(req0_tdst_dsc_n), 32'(k != 8));
      next_cycle();
    end
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge phyclk);
    check("wdt_idle_grant", 32'(grant), 32'h0);
    check("wdt_idle_abort", 32'(wdt_abort), 32'h0);
    next_cycle();
    t_rdy_n = 1'b0;
`else
    for (int k = 1; k <= 12; k++) begin
      @(negedge phyclk);
      check($sformatf("hold_grant%0d", k), 32'(grant), 32'h1);
      check($sformatf("hold_dsc%0d", k), {30'h0, trn_tsrc_dsc_n, req0_tdst_dsc_n}, 32'h3);
      check($sformatf("hold_abort%0d", k), 32'(wdt_abort), 32'h0);
      next_cycle();
    end
    t_rdy_n = 1'b0;
    @(negedge phyclk);
    check("hold_single_eof", 32'(trn_teof_n), 32'h0);
    next_cycle();
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge phyclk);
    check("hold_done_grant", 32'(grant), 32'h0);
    next_cycle();
`endif

    // Reset mid-frame drops the grant with no discontinue pulse.
    drv0(1'b0, 1'b0, 1'b1, 32'h55);
    t_rdy_n = 1'b1;
    next_cycle();
    @(negedge phyclk);
    check("mrst_pre_grant", 32'(grant), 32'h1);
    next_cycle();
    phyreset_n = 1'b0;
    drv0(1'b1, 1'b1, 1'b1, 32'h0);
    next_cycle();
    @(negedge phyclk);
    check("mrst_grant", 32'(grant), 32'h0);
    check("mrst_dsc", {30'h0, req0_tdst_dsc_n, trn_tsrc_dsc_n}, 32'h3);
    next_cycle();
    phyreset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/txll_arb.md
# txll_arb

Frame-atomic two-requester arbiter in front of the SATA link-layer transmit port. It shares one trn_t* transmit interface between a command/control FIS source (requester 0) and a data FIS source (requester 1). Arbitration is round-robin at frame granularity, and a granted requester keeps the port from SOF through EOF. It sits between the transport-layer FIS builders and the TX link-layer FIFO reader, in the phyclk domain.

## Interface
Parameters:
- C_TIMEOUT, 1023: stalled-frame watchdog limit in phyclk cycles; range 2..65535; used only with SATA_TXARB_WDT_EN.

Ports:
- phyclk  in  1  sole clock; all state on rising edge.
- phyreset_n  in  1  synchronous, active-low reset.
- req0_td / req1_td  in  32  requester data.
- req0_tsof_n / req1_tsof_n  in  1  start-of-frame, active low.
- req0_teof_n / req1_teof_n  in  1  end-of-frame, active low.
- req0_tsrc_rdy_n / req1_tsrc_rdy_n  in  1  requester beat valid, active low.
- req0_tdst_rdy_n / req1_tdst_rdy_n  out  1  beat accepted from requester, active low.
- req0_tdst_dsc_n / req1_tdst_dsc_n  out  1  frame discontinued, active low, one-cycle pulse.
- trn_td  out  32  link-layer data.
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n  out  1 each  link-layer framing and valid, active low.
- trn_tdst_rdy_n, trn_tdst_dsc_n  in  1 each  link-layer ready and discontinue, active low.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- err_nosof  out  1  one-cycle pulse per discarded non-SOF head beat.
- wdt_abort  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

## Operation
- States are IDLE, GNT0 and GNT1. last_grant is a 1-bit register.
- IDLE: a requester is eligible when tsrc_rdy_n=0 and tsof_n=0.
  - If one requester is eligible, it wins.
  - If both are eligible, the requester != last_grant wins.
  - The winner moves the state to GNTi on the next edge.
- IDLE, non-SOF head beat: a requester with tsrc_rdy_n=0 and tsof_n=1 has its tdst_rdy_n driven 0 combinationally and the beat is discarded. err_nosof pulses the same cycle. This is evaluated per requester, in parallel with arbitration.
- IDLE outputs: trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0.
- GNTi: the trn_td/tsof_n/teof_n/tsrc_rdy_n outputs are a combinational pass-through of requester i.
  - reqi_tdst_rdy_n = trn_tdst_rdy_n.
  - The other requester's tdst_rdy_n = 1.
- GNTi, frame completion: a beat is accepted when trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0. An accepted beat with teof_n=0 sets last_grant=i and returns to IDLE on the next edge.
- GNTi, link-layer discontinue: trn_tdst_dsc_n=0 drives reqi_tdst_dsc_n=0 combinationally and returns to IDLE; last_grant=i.
  - The requester drops the remainder of its frame.
  - The remainder then arrives in IDLE as non-SOF beats and is discarded with err_nosof.
- trn_tdst_dsc_n in IDLE is ignored.
- Simultaneous EOF acceptance and trn_tdst_dsc_n=0: discontinue takes precedence, and reqi_tdst_dsc_n still pulses.
- A single-beat frame (tsof_n=0 and teof_n=0 on the same beat) is legal and completes in one accepted beat.

## Timing
- Reset (phyreset_n=0 at an edge) takes effect on that edge:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), grant=00.
  - All _n outputs =1, trn_td=0, err_nosof=0, wdt_abort=0.
- Reset mid-frame abandons the frame silently; no dsc pulse is generated.
- Grant latency: eligible SOF in IDLE at cycle N gives grant and trn_tsof_n=0 at cycle N+1. The requester holds the SOF beat because its tdst_rdy_n=1 at N.
- Inter-frame gap: EOF accepted at M gives IDLE at M+1 and the next grant at M+2, so the minimum is one idle bubble. Back-to-back frames from the same requester follow the same rule.
- The data path carries no pipeline register; trn_td-to-req ready is zero-latency combinational.

## Configuration
- SATA_TXARB_WDT_EN defined:
  - A 16-bit counter clears on grant entry and on every accepted beat, and increments otherwise while in GNTi.
  - When it equals C_TIMEOUT-1, for one cycle:
    - trn_tsrc_dsc_n=0, reqi_tdst_dsc_n=0 and wdt_abort=1.
    - The state returns to IDLE and last_grant=i.
  - Any non-SOF beats the aborted requester still presents are then discarded in IDLE with err_nosof, as for a link-layer discontinue.
- SATA_TXARB_WDT_EN undefined: no counter, trn_tsrc_dsc_n tied 1, wdt_abort tied 0, and a grant persists indefinitely.

## Test plan
- Reset release, req0 only sends a 4-beat frame (0xA0..0xA3), trn_tdst_rdy_n=0 -> grant=01 one cycle after SOF, 4 trn beats in order, return to IDLE, err_nosof never pulses.
- Both requesters present SOF on the same cycle, repeated for 4 frames -> grants alternate 0,1,0,1 with exactly one idle cycle between frames.
- trn_tdst_rdy_n toggled every other cycle during a 3-beat req1 frame -> req0 tdst_rdy_n stays 1 throughout, all 3 beats delivered, no duplicates.
- trn_tdst_dsc_n=0 on the 2nd beat of a req0 frame -> req0_tdst_dsc_n pulses the same cycle, the next cycle is IDLE, and a pending req1 SOF is granted on the following cycle.
- req1 presents a non-SOF beat 0xDEAD in IDLE -> that beat is consumed, err_nosof pulses once, and grant stays 00.
- With SATA_TXARB_WDT_EN and C_TIMEOUT=8: grant to req0, trn_tdst_rdy_n held 1 -> trn_tsrc_dsc_n, req0_tdst_dsc_n and wdt_abort pulse on the 8th granted cycle, then IDLE.
